// File: rtl/iexec_stage.sv
// rtl/iexec_stage.sv - MIPS execute stage: forwarding, ALU, branch/jump resolve, EX/MEM latch
module iexec_stage #(
  parameter int WORD_W  = 32,
  parameter int JAL_REG = 31
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [WORD_W-1:0] rdat1,
  input  logic [WORD_W-1:0] rdat2,
  input  logic [WORD_W-1:0] ext_imm,
  input  logic [15:0]       imm16,
  input  logic [WORD_W-1:0] pcplusfour,
  input  logic [WORD_W-1:0] j_target,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic              regwr,
  input  logic              dren,
  input  logic              dwen,
  input  logic              memtoreg,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic              halt,
  input  logic              mem_regwr,
  input  logic [4:0]        mem_wsel,
  input  logic [WORD_W-1:0] mem_fdat,
  input  logic              wb_regwr,
  input  logic [4:0]        wb_wsel,
  input  logic [WORD_W-1:0] wb_fdat,
  input  logic              advance,
  input  logic              flush,
  output logic              redirect,
  output logic [WORD_W-1:0] redirect_pc,
  output logic              xm_valid,
  output logic              xm_regwr,
  output logic              xm_dren,
  output logic              xm_dwen,
  output logic              xm_memtoreg,
  output logic              xm_halt,
  output logic [WORD_W-1:0] xm_alu,
  output logic [WORD_W-1:0] xm_store,
  output logic [4:0]        xm_wsel,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  logic [WORD_W-1:0] a_fwd, b_fwd, b_op, alu_res;
  logic              known;
  logic [4:0]        wsel;
  logic              commit;

  // MEM is the younger producer, so it wins over WB; $zero is never forwarded.
  always_comb begin
    a_fwd = rdat1;
    if (mem_regwr && mem_wsel == rs && rs != 5'd0)    a_fwd = mem_fdat;
    else if (wb_regwr && wb_wsel == rs && rs != 5'd0) a_fwd = wb_fdat;
    b_fwd = rdat2;
    if (mem_regwr && mem_wsel == rt && rt != 5'd0)    b_fwd = mem_fdat;
    else if (wb_regwr && wb_wsel == rt && rt != 5'd0) b_fwd = wb_fdat;
  end

  assign b_op = alusrc ? ext_imm : b_fwd;

  always_comb begin
    alu_res = '0;
    known   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_res = a_fwd + b_op;
          FN_SUBU: alu_res = a_fwd - b_op;
          FN_AND:  alu_res = a_fwd & b_op;
          FN_OR:   alu_res = a_fwd | b_op;
          FN_XOR:  alu_res = a_fwd ^ b_op;
          FN_NOR:  alu_res = ~(a_fwd | b_op);
          FN_SLT:  alu_res = WORD_W'($signed(a_fwd) < $signed(b_op));
          FN_SLTU: alu_res = WORD_W'(a_fwd < b_op);
          FN_SLL:  alu_res = b_fwd << shamt;
          FN_SRL:  alu_res = b_fwd >> shamt;
          FN_JR:   alu_res = '0;
          default: known   = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_res = a_fwd + b_op;
      OP_ANDI:  alu_res = a_fwd & b_op;
      OP_ORI:   alu_res = a_fwd | b_op;
      OP_XORI:  alu_res = a_fwd ^ b_op;
      OP_SLTI:  alu_res = WORD_W'($signed(a_fwd) < $signed(b_op));
      OP_SLTIU: alu_res = WORD_W'(a_fwd < b_op);
      OP_LUI:   alu_res = WORD_W'({imm16, 16'h0000});
      OP_JAL:   alu_res = pcplusfour;
      OP_J, OP_BEQ, OP_BNE, OP_HALT: alu_res = '0;
      default:  known   = 1'b0;
    endcase
  end

  assign wsel = (opcode == OP_JAL) ? 5'(JAL_REG) : (regdst ? rd : rt);

  // Branches compare the forwarded registers, never the immediate-muxed B.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pcplusfour;
    if (id_valid && !flush && !halted) begin
      case (opcode)
        OP_BEQ: if (a_fwd == b_fwd) begin
          redirect    = 1'b1;
          redirect_pc = pcplusfour + (ext_imm << 2);
        end
        OP_BNE: if (a_fwd != b_fwd) begin
          redirect    = 1'b1;
          redirect_pc = pcplusfour + (ext_imm << 2);
        end
        OP_J, OP_JAL: begin
          redirect    = 1'b1;
          redirect_pc = j_target;
        end
        OP_RTYPE: if (funct == FN_JR) begin
          redirect    = 1'b1;
          redirect_pc = a_fwd;
        end
        default: ;
      endcase
    end
  end

  assign commit = advance && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      xm_valid    <= 1'b0;
      xm_regwr    <= 1'b0;
      xm_dren     <= 1'b0;
      xm_dwen     <= 1'b0;
      xm_memtoreg <= 1'b0;
      xm_halt     <= 1'b0;
      xm_alu      <= '0;
      xm_store    <= '0;
      xm_wsel     <= '0;
      halted      <= 1'b0;
    end else if (advance) begin
      if (flush) begin
        xm_valid    <= 1'b0;
        xm_regwr    <= 1'b0;
        xm_dren     <= 1'b0;
        xm_dwen     <= 1'b0;
        xm_memtoreg <= 1'b0;
        xm_halt     <= 1'b0;
        xm_alu      <= '0;
        xm_store    <= '0;
        xm_wsel     <= '0;
      end else begin
        xm_valid    <= id_valid;
        xm_regwr    <= id_valid & regwr & known;
        xm_dren     <= id_valid & dren;
        xm_dwen     <= id_valid & dwen;
        xm_memtoreg <= id_valid & memtoreg;
        xm_halt     <= id_valid & halt;
        xm_alu      <= alu_res;
        xm_store    <= b_fwd;
        xm_wsel     <= wsel;
      end
      if (commit && id_valid && halt) halted <= 1'b1;
    end
  end

endmodule

// File: doc/iexec_stage.md
Name: iexec_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX latch outputs and applies operand forwarding from MEM and WB.
- Performs the ALU operation and resolves branches and jumps, driving the fetch redirect.
- Registers its results into the EX/MEM latch consumed by the memory stage.

Parameters:
- WORD_W, 32, datapath width (word_t).
- JAL_REG, 31, destination register number for JAL.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- id_valid  input  1  ID/EX slot holds a real instruction
- opcode  input  6  opcode_t
- funct  input  6  funct_t (R-type)
- shamt  input  5  shift amount
- rdat1, rdat2  input  32  register file reads for rs, rt
- ext_imm  input  32  sign/zero-extended immediate
- imm16  input  16  raw immediate (LUI)
- pcplusfour  input  32  PC+4 of instruction
- j_target  input  32  precomputed jump target
- rs, rt, rd  input  5  register specifiers
- regwr, dren, dwen, memtoreg, regdst, alusrc, halt  input  1  decoded controls
- mem_regwr  input  1  forwarding source: EX/MEM write enable
- mem_wsel  input  5  forwarding source: EX/MEM destination
- mem_fdat  input  32  forwarding source: EX/MEM data
- wb_regwr  input  1  forwarding source: MEM/WB write enable
- wb_wsel  input  5  forwarding source: MEM/WB destination
- wb_fdat  input  32  forwarding source: MEM/WB data
- advance  input  1  EX/MEM latch enable (ihit & ~mem stall)
- flush  input  1  squash the instruction entering EX/MEM
- redirect  output  1  taken branch/jump; fetch must load redirect_pc
- redirect_pc  output  32  next PC on redirect
- xm_valid, xm_regwr, xm_dren, xm_dwen, xm_memtoreg, xm_halt  output  1  registered controls
- xm_alu  output  32  registered ALU result / address
- xm_store  output  32  registered forwarded rt data
- xm_wsel  output  5  registered destination register
- halted  output  1  sticky halt

Behaviour:
- Forwarding, per operand (rs→A, rt→B):
  - If mem_regwr and mem_wsel==src and src!=0, use mem_fdat.
  - Else if wb_regwr and wb_wsel==src and src!=0, use wb_fdat.
  - Else use rdat. MEM has priority over WB.
- B operand: ext_imm when alusrc, else forwarded rt.
- ALU decode:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL. Shifts use shamt on forwarded rt.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LW/SW (A+ext_imm), LUI ({imm16,16'h0}).
  - JAL: result = pcplusfour.
  - Arithmetic wraps modulo 2^32; no overflow traps.
  - Unknown opcode: result 0, regwr forced 0.
- Destination: JAL → JAL_REG; regdst → rd; otherwise rt.
- Redirect (combinational, qualified by id_valid & ~flush):
  - BEQ with A==B, or BNE with A!=B → pcplusfour + (ext_imm<<2).
  - J / JAL → j_target.
  - JR (R-type) → forwarded A.
  - Otherwise redirect=0, redirect_pc=pcplusfour.
- EX/MEM latch:
  - nRST low: all xm_* outputs and halted = 0, asynchronously.
  - advance & flush: load bubble (xm_valid=0, all xm control bits 0, data 0).
  - advance & ~flush: load computed values. xm_valid=id_valid. Controls are ANDed with id_valid.
  - ~advance: hold all values; flush is ignored until advance.
- Halt: halted sets on the cycle a valid halt is latched (xm_halt rising). It stays set until reset. While halted, redirect=0.
- Reset mid-operation clears the latch and halted immediately; forwarding paths stay combinational.

Test Plan:
- ADDU, rdat1=5, rdat2=7, rd=3, advance=1 → next edge: xm_alu=12, xm_wsel=3, xm_regwr=1, xm_valid=1.
- Forwarding: rs=4, mem_regwr=1, mem_wsel=4, mem_fdat=0x10, wb also wsel=4 with 0x99 → A=0x10. With mem_wsel=0, use wb_fdat only if src!=0; with rs=0, rdat1 is used.
- BEQ, A=B=8, pcplusfour=0x100, ext_imm=0xFFFFFFFF → redirect=1, redirect_pc=0xFC. With B=9 → redirect=0.
- JAL, pcplusfour=0x40, j_target=0x200 → redirect_pc=0x200. Latched xm_alu=0x40, xm_wsel=31.
- advance=0 for 3 cycles with changing inputs → xm_* constant. Then flush=1 with advance=1 → xm_valid=0, xm_regwr=0.
- Valid HALT latched → halted=1. Assert nRST low mid-cycle → all outputs 0 before the next edge.
